sseg_share_arb: RTL and testbench
=================================

// Module: sseg_share_arb
// PURPOSE
//  Shares the 4-digit seven-segment display between two client blocks.
//  Each client requests ownership and presents 4 digit-pattern bytes.
//  The arbiter grants one owner at a time, round-robin, with a minimum time slice.
//  Its in0..in3 outputs feed disp_mux directly; with no owner, all digits are blanked.
// PARAMETERS
//  HOLD_CYCLES  50_000_000  min cycles an owner keeps the display while the other client waits (>=2)
//  BLANK        8'hFF       pattern driven on every digit when idle (active-low segs, all off)
//  CW           $clog2(HOLD_CYCLES+1)  hold-counter width (derived, do not override)
// PORTS
//  clk     in   1   system clock
//  reset   in   1   synchronous, active-high reset
//  req     in   2   req[k]=1: client k wants the display (level, held while owning)
//  c0_d    in   32  client 0 digit patterns: [7:0]=digit0 .. [31:24]=digit3
//  c1_d    in   32  client 1 digit patterns, same packing
//  gnt     out  2   one-hot grant; 2'b00 when idle
//  busy    out  1   |gnt
//  in0     out  8   digit0 pattern to disp_mux (in1..in3 likewise, 8 bits each)
// BEHAVIOUR
//  - Clock/reset: one clock (clk); reset is synchronous and active-high.
//  - Registered outputs:
//    - All outputs are registered.
//    - Reset: state=IDLE, gnt=0, busy=0, in0..in3=BLANK, hold_cnt=0, last=1.
//    - last=1 makes client 0 win the first tie.
//  - States: IDLE, OWN0, OWN1.
//  - IDLE:
//    - Outputs: gnt=0, in*=BLANK.
//    - Exactly one req set: go to that client's OWN.
//    - Both req set: go to OWN of client != last.
//  - OWNk, with j the other client:
//    - hold_cnt increments each cycle and saturates at HOLD_CYCLES.
//    - req[k]=0: leave next edge. Go to OWNj if req[j]=1, else IDLE.
//    - req[k]=1, req[j]=1, hold_cnt==HOLD_CYCLES-1: preempt and go to OWNj.
//    - Otherwise stay in OWNk.
//  - Any state change:
//    - hold_cnt<=0.
//    - last<=k of the new owner; last is unchanged on a transition to IDLE.
//  - Latency:
//    - req edge sampled at edge N gives gnt at N (registered, visible after N).
//    - in0..in3 are loaded on the same edge from the new owner's cK_d.
//    - While owning, in* track cK_d with 1-cycle latency. A going-IDLE edge loads BLANK.
//  - Switch OWN0<->OWN1: gnt goes 01->10 in one edge; gnt is never 11 or 00 mid-switch.
//  - Data of the non-owner is ignored.
//  - Reset mid-ownership:
//    - Next edge forces IDLE and blank output regardless of req.
//    - Leaving reset with req held re-arbitrates from IDLE.
//  - Counter width: CW bits; no wrap because it saturates.
// TESTING (bench uses HOLD_CYCLES=4, clk period 10)
//  1 reset 5 cycles, req=00 -> gnt=00, busy=0, in0..in3=8'hFF throughout.
//  2 req=01, c0_d=32'h0F_F0_55_AA -> next edge: gnt=01.
//    in0=AA, in1=55, in2=F0, in3=0F.
//    Change c0_d: in* follow 1 cycle later.
//  3 from reset, req=11 in IDLE -> gnt=01.
//    After 4 owned cycles: gnt=10, in* = c1_d.
//    After 4 more: gnt=01 (round-robin alternation).
//  4 gnt=01, req=01 for 10 cycles -> gnt stays 01 (no preempt without competitor).
//    Drop req to 00 -> next edge gnt=00, in*=FF.
//  5 gnt=10, req[1] drops while req[0]=1 -> next edge gnt=01 directly, no idle cycle.
//  6 gnt=10, assert reset 1 cycle with req=11 -> gnt=00, in*=FF.
//    Release: gnt=01 (last reset to 1).

Source files
------------

// File: rtl/sseg_share_arb.sv
// Round-robin arbiter that shares the 4-digit seven-segment display between two clients.
// Grants one owner at a time with a minimum time slice; blanks all digits when idle.
module sseg_share_arb #(
  parameter int          HOLD_CYCLES = 50_000_000,
  parameter logic [7:0]  BLANK       = 8'hFF,
  parameter int          CW          = $clog2(HOLD_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [31:0] c0_d,
  input  logic [31:0] c1_d,
  output logic [1:0]  gnt,
  output logic        busy,
  output logic [7:0]  in0,
  output logic [7:0]  in1,
  output logic [7:0]  in2,
  output logic [7:0]  in3
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [CW-1:0] HOLD_MAX  = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] hold_cnt, hold_cnt_nxt;
  logic          last, last_nxt;
  logic [31:0]   disp_nxt;

  // Next owner, slice counter and display data are all decided here and
  // registered together, so gnt and in0..in3 change on the same edge.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    last_nxt     = last;
    disp_nxt     = {4{BLANK}};

    unique case (state)
      IDLE: begin
        if (req == 2'b11)      state_nxt = last ? OWN0 : OWN1;
        else if (req[0])       state_nxt = OWN0;
        else if (req[1])       state_nxt = OWN1;
      end
      OWN0: begin
        if (!req[0])                              state_nxt = req[1] ? OWN1 : IDLE;
        else if (req[1] && hold_cnt == HOLD_LAST) state_nxt = OWN1;
      end
      OWN1: begin
        if (!req[1])                              state_nxt = req[0] ? OWN0 : IDLE;
        else if (req[0] && hold_cnt == HOLD_LAST) state_nxt = OWN0;
      end
      default: state_nxt = IDLE;
    endcase

    if (state_nxt != state) begin
      hold_cnt_nxt = '0;
      if (state_nxt == OWN0) last_nxt = 1'b0;
      if (state_nxt == OWN1) last_nxt = 1'b1;
    end else if (state != IDLE && hold_cnt != HOLD_MAX) begin
      hold_cnt_nxt = hold_cnt + 1'b1;
    end

    if (state_nxt == OWN0) disp_nxt = c0_d;
    if (state_nxt == OWN1) disp_nxt = c1_d;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
      last     <= 1'b1;
      gnt      <= 2'b00;
      busy     <= 1'b0;
      in0      <= BLANK;
      in1      <= BLANK;
      in2      <= BLANK;
      in3      <= BLANK;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
      last     <= last_nxt;
      gnt      <= {state_nxt == OWN1, state_nxt == OWN0};
      busy     <= (state_nxt != IDLE);
      in0      <= disp_nxt[7:0];
      in1      <= disp_nxt[15:8];
      in2      <= disp_nxt[23:16];
      in3      <= disp_nxt[31:24];
    end
  end

endmodule

// File: tb/tb_sseg_share_arb.sv
// Directed bench for sseg_share_arb with HOLD_CYCLES=4; expected values are hand-computed.
module tb_sseg_share_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [31:0] c0_d, c1_d;
  logic [1:0]  gnt;
  logic        busy;
  logic [7:0]  in0, in1, in2, in3;

  int n_checks = 0;
  int n_fails  = 0;

  localparam logic [31:0] BLANK4 = 32'hFFFF_FFFF;

  sseg_share_arb #(.HOLD_CYCLES(4), .BLANK(8'hFF)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .c0_d  (c0_d),
    .c1_d  (c1_d),
    .gnt   (gnt),
    .busy  (busy),
    .in0   (in0),
    .in1   (in1),
    .in2   (in2),
    .in3   (in3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] disp();
    return {in3, in2, in1, in0};
  endfunction

  task automatic check_out(input string tag, input logic [1:0] exp_gnt, input logic [31:0] exp_disp);
    check({tag, ".gnt"},  {30'd0, gnt},  {30'd0, exp_gnt});
    check({tag, ".busy"}, {31'd0, busy}, {31'd0, |exp_gnt});
    check({tag, ".disp"}, disp(),        exp_disp);
  endtask

  initial begin
    reset = 1'b1;
    req   = 2'b00;
    c0_d  = 32'h0000_0000;
    c1_d  = 32'h0000_0000;

    // 1: reset held for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out("t1_reset", 2'b00, BLANK4);
    end

    // 2: single requester, data follows with one cycle latency
    reset = 1'b0;
    tick();
    check_out("t2_idle", 2'b00, BLANK4);
    req  = 2'b01;
    c0_d = 32'h0FF0_55AA;
    tick();
    check_out("t2_grant", 2'b01, 32'h0FF0_55AA);
    c0_d = 32'h1234_5678;
    #1;
    check("t2_no_edge_yet", disp(), 32'h0FF0_55AA);
    tick();
    check_out("t2_follow", 2'b01, 32'h1234_5678);

    // 3: from reset both request -> client 0 first, then 4-cycle slices alternate
    reset = 1'b1;
    req   = 2'b11;
    c0_d  = 32'hA0A1_A2A3;
    c1_d  = 32'hB0B1_B2B3;
    tick();
    check_out("t3_reset", 2'b00, BLANK4);
    reset = 1'b0;
    tick();
    check_out("t3_first", 2'b01, 32'hA0A1_A2A3);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("t3_hold0", 2'b01, 32'hA0A1_A2A3);
    end
    tick();
    check_out("t3_switch1", 2'b10, 32'hB0B1_B2B3);
    c0_d = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("t3_hold1", 2'b10, 32'hB0B1_B2B3);
    end
    tick();
    check_out("t3_switch0", 2'b01, 32'hDEAD_BEEF);

    // 4: no competitor -> no preemption; release goes idle
    req = 2'b01;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_out("t4_keep", 2'b01, 32'hDEAD_BEEF);
    end
    req = 2'b00;
    tick();
    check_out("t4_release", 2'b00, BLANK4);

    // 5: owner 1 drops while client 0 waits -> direct handover
    req = 2'b10;
    tick();
    check_out("t5_own1", 2'b10, 32'hB0B1_B2B3);
    req = 2'b11;
    tick();
    check_out("t5_both", 2'b10, 32'hB0B1_B2B3);
    req = 2'b01;
    tick();
    check_out("t5_handover", 2'b01, 32'hDEAD_BEEF);

    // 6: reset while owning client 1, release re-arbitrates to client 0
    req = 2'b10;
    tick();
    check_out("t6_own1", 2'b10, 32'hB0B1_B2B3);
    req   = 2'b11;
    reset = 1'b1;
    tick();
    check_out("t6_reset", 2'b00, BLANK4);
    reset = 1'b0;
    tick();
    check_out("t6_rearb", 2'b01, 32'hDEAD_BEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
